// File: rtl/feeder_pkg.sv
// Shared types and constants for the serial word feeder.
// FEEDER_PARITY_EN prepends an even-parity bit to every frame.
package feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

`ifdef FEEDER_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

endpackage

// File: rtl/feeder_bitcnt.sv
// Frame bit counter: clear on load, count up on inc, flag the last bit.
module feeder_bitcnt #(
    parameter int CW   = 3,
    parameter int LAST = 3
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_load,
    input  logic i_inc,
    output logic o_tc
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == CW'(LAST));

endmodule

// File: rtl/serial_word_feeder.sv
// Serialises parallel words into d/en/dir for a downstream shift register.
// Build option FEEDER_PARITY_EN sends an even-parity bit ahead of the data.
module serial_word_feeder
    import feeder_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    output logic             in_ready,
    output logic             d,
    output logic             en,
    output logic             dir,
    output logic             done
);

    localparam int N  = WIDTH + PARITY_BITS;
    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state, w_nstate;
    logic [WIDTH-1:0] r_sh, w_sh;
    logic             r_ready, w_ready;
    logic             r_d, w_d;
    logic             r_en, w_en;
    logic             r_dir, w_dir;
    logic             r_done, w_done;
    logic             w_load, w_inc, w_tc;
    logic             w_accept;

    feeder_bitcnt #(
        .CW   (CW),
        .LAST (N - 1)
    ) u_bitcnt (
        .clk    (clk),
        .rstn   (rstn),
        .i_load (w_load),
        .i_inc  (w_inc),
        .o_tc   (w_tc)
    );

    assign w_accept = (r_state == IDLE) && r_ready && in_valid;

    always_comb begin
        w_nstate = r_state;
        w_sh     = r_sh;
        w_ready  = 1'b0;
        w_d      = 1'b0;
        w_en     = 1'b0;
        w_dir    = r_dir;
        w_done   = 1'b0;
        w_load   = 1'b0;
        w_inc    = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (w_accept) begin
                    w_nstate = SHIFT;
                    w_ready  = 1'b0;
                    w_load   = 1'b1;
                    w_en     = 1'b1;
                    w_dir    = in_dir;
`ifdef FEEDER_PARITY_EN
                    w_d  = ^in_data;
                    w_sh = in_data;
`else
                    // first data bit goes out now; keep the rest queued
                    w_d  = in_dir ? in_data[0] : in_data[WIDTH-1];
                    w_sh = in_dir ? (in_data >> 1) : (in_data << 1);
`endif
                end
            end
            SHIFT: begin
                if (w_tc) begin
                    w_nstate = DONE;
                    w_done   = 1'b1;
                end else begin
                    w_inc = 1'b1;
                    w_en  = 1'b1;
                    w_d   = r_dir ? r_sh[0] : r_sh[WIDTH-1];
                    w_sh  = r_dir ? (r_sh >> 1) : (r_sh << 1);
                end
            end
            DONE: begin
                w_nstate = IDLE;
                w_ready  = 1'b1;
            end
            default: begin
                w_nstate = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_sh    <= '0;
            r_ready <= 1'b0;
            r_d     <= 1'b0;
            r_en    <= 1'b0;
            r_dir   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_sh    <= w_sh;
            r_ready <= w_ready;
            r_d     <= w_d;
            r_en    <= w_en;
            r_dir   <= w_dir;
            r_done  <= w_done;
        end
    end

    assign in_ready = r_ready;
    assign d        = r_d;
    assign en       = r_en;
    assign dir      = r_dir;
    assign done     = r_done;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed bench for serial_word_feeder (WIDTH=4) with a downstream
// shift register model; follows FEEDER_PARITY_EN when defined.
module tb_serial_word_feeder;

    localparam int WIDTH = 4;
`ifdef FEEDER_PARITY_EN
    localparam int N = 5;
    localparam logic [4:0] SEQ_1011_D0 = 5'b11011;
    localparam logic [4:0] SEQ_1011_D1 = 5'b11101;
    localparam logic [4:0] SEQ_0110_D0 = 5'b00110;
`else
    localparam int N = 4;
    localparam logic [4:0] SEQ_1011_D0 = 5'b01011;
    localparam logic [4:0] SEQ_1011_D1 = 5'b01101;
    localparam logic [4:0] SEQ_0110_D0 = 5'b00110;
`endif

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_dir = 1'b0;
    logic             in_ready, d, en, dir, done;

    logic [WIDTH-1:0] q = '0;
    int               cyc = 0;
    int               acc_cnt = 0;
    int               acc_cyc [0:63];
    int               checks = 0;
    int               errors = 0;

    serial_word_feeder #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_dir   (in_dir),
        .in_ready (in_ready),
        .d        (d),
        .en       (en),
        .dir      (dir),
        .done     (done)
    );

    always #5 clk = ~clk;

    // downstream shift register
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (en) q <= dir ? {d, q[WIDTH-1:1]} : {q[WIDTH-2:0], d};
        if (rstn && in_valid && in_ready) begin
            acc_cyc[acc_cnt[5:0]] <= cyc;
            acc_cnt <= acc_cnt + 1;
        end
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, en, d, dir, done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outs: got %b want 00000",
                     {in_ready, en, d, dir, done});
        end
        rstn = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b want 0", in_ready);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge: got %b want 1", in_ready);
        end
    endtask

    task automatic test_frame(input logic [WIDTH-1:0] data,
                              input logic dr,
                              input logic [4:0] seq,
                              input string name);
        int t;
        t = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_timeout: got %b want 1", name, in_ready);
        end
        in_valid = 1'b1;
        in_data  = data;
        in_dir   = dr;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~data;
        in_dir   = ~dr;
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({en, d, dir} !== {1'b1, seq[N-1-i], dr}) begin
                errors++;
                $display("FAIL %s_bit%0d: got en/d/dir %b want %b", name, i,
                         {en, d, dir}, {1'b1, seq[N-1-i], dr});
            end
            @(negedge clk);
        end
        checks++;
        if ({done, en, d, in_ready} !== 4'b1000) begin
            errors++;
            $display("FAIL %s_done: got done/en/d/rdy %b want 1000", name,
                     {done, en, d, in_ready});
        end
        checks++;
        if (q !== data) begin
            errors++;
            $display("FAIL %s_dsreg: got %b want %b", name, q, data);
        end
        @(negedge clk);
        checks++;
        if ({done, in_ready, dir} !== {2'b01, dr}) begin
            errors++;
            $display("FAIL %s_idle: got done/rdy/dir %b want %b", name,
                     {done, in_ready, dir}, {2'b01, dr});
        end
    endtask

    task automatic test_back_to_back();
        int base;
        int t;
        @(negedge clk);
        base     = acc_cnt;
        in_valid = 1'b1;
        in_data  = 4'b0110;
        in_dir   = 1'b0;
        t = 0;
        while (acc_cnt == base && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (acc_cnt != base + 1) begin
            errors++;
            $display("FAIL b2b_first_accept: got %0d want %0d",
                     acc_cnt - base, 1);
        end
        in_data = 4'b1001;
        for (int i = 0; i <= N; i++) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_ready_busy%0d: got %b want 0", i, in_ready);
            end
            if (i == N) begin
                checks++;
                if ({done, q} !== {1'b1, 4'b0110}) begin
                    errors++;
                    $display("FAIL b2b_first_frame: got done/q %b want 10110",
                             {done, q});
                end
            end
            @(negedge clk);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_idle: got %b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (acc_cnt != base + 2) begin
            errors++;
            $display("FAIL b2b_second_accept: got %0d want %0d",
                     acc_cnt - base, 2);
        end else begin
            checks++;
            if (acc_cyc[(base + 1) % 64] - acc_cyc[base % 64] != N + 2) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d want %0d",
                         acc_cyc[(base + 1) % 64] - acc_cyc[base % 64], N + 2);
            end
        end
        repeat (N) @(negedge clk);
        checks++;
        if ({done, q} !== {1'b1, 4'b1001}) begin
            errors++;
            $display("FAIL b2b_second_frame: got done/q %b want 11001",
                     {done, q});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'b1011;
        in_dir   = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({en, d, dir} !== 3'b111) begin
            errors++;
            $display("FAIL abort_pre: got en/d/dir %b want 111", {en, d, dir});
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({en, d, dir, done, in_ready} !== 5'b0) begin
            errors++;
            $display("FAIL abort_async: got en/d/dir/done/rdy %b want 00000",
                     {en, d, dir, done, in_ready});
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready: got %b want 1", in_ready);
        end
        for (int i = 0; i < N + 2; i++) begin
            checks++;
            if ({done, en} !== 2'b00) begin
                errors++;
                $display("FAIL abort_quiet%0d: got done/en %b want 00", i,
                         {done, en});
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_frame(4'b1011, 1'b0, SEQ_1011_D0, "d0_1011");
        test_frame(4'b1011, 1'b1, SEQ_1011_D1, "d1_1011");
        test_back_to_back();
        test_reset_abort();
        test_frame(4'b0110, 1'b0, SEQ_0110_D0, "post_abort");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
